pi_vel_ctrl_mc: RTL and testbench

N-channel velocity control core, the parametrised successor of the single-axis PI velocity motor block. Per channel it does x4 quadrature decoding, sampled velocity measurement, PI control with integrator clamping and anti-windup, and sign/magnitude PWM drive. One sequential PI engine is time-multiplexed across channels. It sits between the AXI register block (gains, setpoints, readback) and the H-bridge pins.

---
 rtl/pi_vel_ctrl_mc.sv | 282 ++++++++++++++++++++++++++++
 tb/tb_pi_vel_ctrl_mc.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/pi_vel_ctrl_mc.sv
// rtl/pi_vel_ctrl_mc.sv - N-channel quadrature velocity PI controller with sign/magnitude PWM drive
// One time-multiplexed PI engine serves every channel; new outputs commit to all channels together.
module pi_vel_ctrl_mc #(
    parameter int N_CH       = 2,
    parameter int PWM_W      = 10,
    parameter int SAMPLE_DIV = 100000,
    parameter int FRAC_SHIFT = 8,
    parameter int INT_LIM    = 1000000
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N_CH-1:0]      encoder_a,
    input  logic [N_CH-1:0]      encoder_b,
    input  logic [N_CH-1:0]      enable,
    input  logic [16*N_CH-1:0]   kp,
    input  logic [16*N_CH-1:0]   ki,
    input  logic [32*N_CH-1:0]   desired_vel,
    output logic [32*N_CH-1:0]   actual_vel,
    output logic [32*N_CH-1:0]   actual_pos,
    output logic [16*N_CH-1:0]   ctrl_signal,
    output logic [N_CH-1:0]      pwm_out,
    output logic [N_CH-1:0]      dir1,
    output logic [N_CH-1:0]      dir2,
    output logic [N_CH-1:0]      enc_err,
    output logic                 sample_tick,
    output logic                 busy
);

    localparam int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int TMR_W = $clog2(SAMPLE_DIV);

    localparam logic signed [48:0] U_POS   = 49'((1 << PWM_W) - 1);
    localparam logic signed [48:0] U_NEG   = -U_POS;
    localparam logic signed [32:0] ERR_POS = 33'sd8388607;
    localparam logic signed [32:0] ERR_NEG = -33'sd8388607;
    localparam logic signed [32:0] I_POS   = 33'(INT_LIM);
    localparam logic signed [32:0] I_NEG   = -I_POS;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ERR,
        S_MUL,
        S_ACC,
        S_SAT,
        S_COMMIT
    } state_t;

    logic [N_CH-1:0][15:0] kp_a, ki_a;
    logic [N_CH-1:0][31:0] des_a;

    assign kp_a  = kp;
    assign ki_a  = ki;
    assign des_a = desired_vel;

    logic [N_CH-1:0] a1_q, a2_q, a3_q, b1_q, b2_q, b3_q;
    logic [N_CH-1:0] a1_d, a2_d, a3_d, b1_d, b2_d, b3_d;
    logic [N_CH-1:0] enc_err_q, enc_err_d;
    logic [N_CH-1:0][31:0] pos_q, pos_d, pos_prev_q, pos_prev_d, vel_q, vel_d;
    logic [TMR_W-1:0] tmr_q, tmr_d;
    logic tick;

    state_t state_q, state_d;
    logic [CH_W-1:0] ch_q, ch_d;
    logic signed [23:0] err_q, err_d;
    logic signed [40:0] p_q, p_d;
    logic signed [31:0] icand_q, icand_d;
    logic signed [48:0] sum_q, sum_d;
    logic [N_CH-1:0][31:0] integ_q, integ_d;
    logic [N_CH-1:0][15:0] u_q, u_d, ctrl_q, ctrl_d;

    logic [PWM_W-1:0] cnt_q, cnt_d;
    logic [N_CH-1:0][PWM_W-1:0] duty_q, duty_d;
    logic [N_CH-1:0] dir1_q, dir1_d, dir2_q, dir2_d, pwm_c;

    assign tick = (tmr_q == TMR_W'(SAMPLE_DIV - 1));

    // Encoder front end, position count and velocity snapshot
    always_comb begin
        a1_d       = encoder_a;
        b1_d       = encoder_b;
        a2_d       = a1_q;
        b2_d       = b1_q;
        a3_d       = a2_q;
        b3_d       = b2_q;
        pos_d      = pos_q;
        pos_prev_d = pos_prev_q;
        vel_d      = vel_q;
        enc_err_d  = enc_err_q;
        tmr_d      = tick ? '0 : tmr_q + TMR_W'(1);
        for (int i = 0; i < N_CH; i++) begin
            case ({a3_q[i], b3_q[i], a2_q[i], b2_q[i]})
                4'b0010, 4'b1011, 4'b1101, 4'b0100: pos_d[i] = pos_q[i] + 32'd1;
                4'b0001, 4'b0111, 4'b1110, 4'b1000: pos_d[i] = pos_q[i] - 32'd1;
                4'b0011, 4'b1100, 4'b0110, 4'b1001: enc_err_d[i] = 1'b1;
                default: ;
            endcase
            // The snapshot uses the registered count, so a step landing now counts next sample
            if (tick) begin
                vel_d[i]      = pos_q[i] - pos_prev_q[i];
                pos_prev_d[i] = pos_q[i];
            end
        end
    end

    logic [15:0] kp_sel, ki_sel;
    logic signed [31:0] des_sel, vel_sel, integ_sel;
    logic signed [32:0] diff, isum;
    logic signed [40:0] prod_p;
    logic signed [48:0] prod_i, full;
    logic signed [15:0] sat_u;
    logic clamped;

    always_comb begin
        state_d   = state_q;
        ch_d      = ch_q;
        err_d     = err_q;
        p_d       = p_q;
        icand_d   = icand_q;
        sum_d     = sum_q;
        integ_d   = integ_q;
        u_d       = u_q;
        ctrl_d    = ctrl_q;

        kp_sel    = kp_a[ch_q];
        ki_sel    = ki_a[ch_q];
        des_sel   = des_a[ch_q];
        vel_sel   = vel_q[ch_q];
        integ_sel = integ_q[ch_q];

        diff   = 33'(des_sel) - 33'(vel_sel);
        isum   = 33'(integ_sel) + 33'(err_q);
        prod_p = 41'($signed({1'b0, kp_sel})) * 41'(err_q);
        prod_i = 49'($signed({1'b0, ki_sel})) * 49'(icand_q);
        full   = 49'(p_q) + prod_i;

        clamped = 1'b0;
        sat_u   = sum_q[15:0];
        if (sum_q > U_POS) begin
            sat_u   = U_POS[15:0];
            clamped = 1'b1;
        end else if (sum_q < U_NEG) begin
            sat_u   = U_NEG[15:0];
            clamped = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (tick) begin
                    state_d = S_ERR;
                    ch_d    = '0;
                end
            end
            S_ERR: begin
                if (diff > ERR_POS)      err_d = ERR_POS[23:0];
                else if (diff < ERR_NEG) err_d = ERR_NEG[23:0];
                else                     err_d = diff[23:0];
                state_d = S_MUL;
            end
            S_MUL: begin
                p_d = prod_p;
                if (isum > I_POS)      icand_d = I_POS[31:0];
                else if (isum < I_NEG) icand_d = I_NEG[31:0];
                else                   icand_d = isum[31:0];
                state_d = S_ACC;
            end
            S_ACC: begin
                sum_d   = full >>> FRAC_SHIFT;
                state_d = S_SAT;
            end
            S_SAT: begin
                // Hold the integrator while the output is pinned and the error pushes further out
                if (enable[ch_q]) begin
                    u_d[ch_q] = sat_u;
                    if (!(clamped && (err_q[23] == sum_q[48]))) integ_d[ch_q] = icand_q;
                end else begin
                    u_d[ch_q]     = '0;
                    integ_d[ch_q] = '0;
                end
                if (ch_q == CH_W'(N_CH - 1)) begin
                    state_d = S_COMMIT;
                end else begin
                    ch_d    = ch_q + CH_W'(1);
                    state_d = S_ERR;
                end
            end
            S_COMMIT: begin
                ctrl_d  = u_q;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    logic signed [15:0] ctrl_i;
    logic [15:0] mag;

    // Duty and direction only reload at the period boundary so a period is never cut short
    always_comb begin
        cnt_d  = cnt_q + PWM_W'(1);
        duty_d = duty_q;
        dir1_d = dir1_q;
        dir2_d = dir2_q;
        ctrl_i = '0;
        mag    = '0;
        pwm_c  = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (&cnt_q) begin
                ctrl_i    = ctrl_q[i];
                mag       = ctrl_i[15] ? 16'(-ctrl_i) : ctrl_i;
                duty_d[i] = PWM_W'(mag);
                dir1_d[i] = !ctrl_i[15] && (ctrl_i != 16'sd0);
                dir2_d[i] = ctrl_i[15];
            end
            pwm_c[i] = (cnt_q < duty_q[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            a1_q       <= '0;
            a2_q       <= '0;
            a3_q       <= '0;
            b1_q       <= '0;
            b2_q       <= '0;
            b3_q       <= '0;
            enc_err_q  <= '0;
            pos_q      <= '0;
            pos_prev_q <= '0;
            vel_q      <= '0;
            tmr_q      <= '0;
            state_q    <= S_IDLE;
            ch_q       <= '0;
            err_q      <= '0;
            p_q        <= '0;
            icand_q    <= '0;
            sum_q      <= '0;
            integ_q    <= '0;
            u_q        <= '0;
            ctrl_q     <= '0;
            cnt_q      <= '0;
            duty_q     <= '0;
            dir1_q     <= '0;
            dir2_q     <= '0;
        end else begin
            a1_q       <= a1_d;
            a2_q       <= a2_d;
            a3_q       <= a3_d;
            b1_q       <= b1_d;
            b2_q       <= b2_d;
            b3_q       <= b3_d;
            enc_err_q  <= enc_err_d;
            pos_q      <= pos_d;
            pos_prev_q <= pos_prev_d;
            vel_q      <= vel_d;
            tmr_q      <= tmr_d;
            state_q    <= state_d;
            ch_q       <= ch_d;
            err_q      <= err_d;
            p_q        <= p_d;
            icand_q    <= icand_d;
            sum_q      <= sum_d;
            integ_q    <= integ_d;
            u_q        <= u_d;
            ctrl_q     <= ctrl_d;
            cnt_q      <= cnt_d;
            duty_q     <= duty_d;
            dir1_q     <= dir1_d;
            dir2_q     <= dir2_d;
        end
    end

    assign actual_vel  = vel_q;
    assign actual_pos  = pos_q;
    assign ctrl_signal = ctrl_q;
    assign pwm_out     = pwm_c;
    assign dir1        = dir1_q;
    assign dir2        = dir2_q;
    assign enc_err     = enc_err_q;
    assign sample_tick = tick;
    assign busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_pi_vel_ctrl_mc.sv
// tb/tb_pi_vel_ctrl_mc.sv - directed vector bench for pi_vel_ctrl_mc
module tb_pi_vel_ctrl_mc;

    localparam int N_CH       = 2;
    localparam int PWM_W      = 10;
    localparam int SAMPLE_DIV = 64;
    localparam int FRAC_SHIFT = 8;
    localparam int INT_LIM    = 600;

    logic                 clk = 1'b0;
    logic                 reset;
    logic [N_CH-1:0]      encoder_a, encoder_b, enable;
    logic [16*N_CH-1:0]   kp, ki;
    logic [32*N_CH-1:0]   desired_vel;
    logic [32*N_CH-1:0]   actual_vel, actual_pos;
    logic [16*N_CH-1:0]   ctrl_signal;
    logic [N_CH-1:0]      pwm_out, dir1, dir2, enc_err;
    logic                 sample_tick, busy;

    pi_vel_ctrl_mc #(
        .N_CH(N_CH), .PWM_W(PWM_W), .SAMPLE_DIV(SAMPLE_DIV),
        .FRAC_SHIFT(FRAC_SHIFT), .INT_LIM(INT_LIM)
    ) dut (
        .clk(clk), .reset(reset),
        .encoder_a(encoder_a), .encoder_b(encoder_b), .enable(enable),
        .kp(kp), .ki(ki), .desired_vel(desired_vel),
        .actual_vel(actual_vel), .actual_pos(actual_pos), .ctrl_signal(ctrl_signal),
        .pwm_out(pwm_out), .dir1(dir1), .dir2(dir2), .enc_err(enc_err),
        .sample_tick(sample_tick), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] kp0, ki0, kp1, ki1;
        logic [31:0] d0, d1;
        logic [1:0]  en;
        logic [15:0] e0, e1;
    } vec_t;

    vec_t vecs [8];
    logic [1:0] gseq [4];
    int gidx = 0;
    int tests = 0;
    int failed = 0;
    int c0, c1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_tick();
        int n = 0;
        @(negedge clk);
        while (sample_tick !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (sample_tick !== 1'b1) begin
            tests++;
            failed++;
            $display("FAIL wait_tick: got no tick expected a tick within 200 cycles");
        end
    endtask

    task automatic apply(input vec_t v);
        kp          = {v.kp1, v.kp0};
        ki          = {v.ki1, v.ki0};
        desired_vel = {v.d1, v.d0};
        enable      = v.en;
    endtask

    // One disabled sample zeroes every integrator and commits zero outputs
    task automatic clear_integ();
        enable = '0;
        wait_tick();
        cyc(11);
    endtask

    task automatic enc_step(input int d);
        gidx = (gidx + d + 4) % 4;
        {encoder_a[0], encoder_b[0]} = gseq[gidx];
        @(negedge clk);
    endtask

    task automatic pwm_count(output int n0, output int n1);
        n0 = 0;
        n1 = 0;
        for (int k = 0; k < 1024; k++) begin
            @(negedge clk);
            if (pwm_out[0]) n0++;
            if (pwm_out[1]) n1++;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish expected finish before 2 ms");
        $fatal(1, "watchdog expired");
    end

    initial begin
        gseq[0] = 2'b00; gseq[1] = 2'b10; gseq[2] = 2'b11; gseq[3] = 2'b01;
        //             kp0      ki0      kp1       ki1      d0              d1              en     e0              e1
        vecs[0] = '{16'd256,   16'd0,   16'd512,   16'd0,   32'd100,        -32'sd30,       2'b11, 16'd100,        -16'sd60};
        vecs[1] = '{16'd128,   16'd0,   16'd128,   16'd0,   32'd101,        -32'sd101,      2'b11, 16'd50,         -16'sd51};
        vecs[2] = '{16'd0,     16'd256, 16'd256,   16'd256, 32'd37,         -32'sd5,        2'b11, 16'd37,         -16'sd10};
        vecs[3] = '{16'd65535, 16'd0,   16'd65535, 16'd0,   -32'sd8000,     32'd8000,       2'b11, -16'sd1023,     16'd1023};
        vecs[4] = '{16'd0,     16'd256, 16'd0,     16'd256, 32'd700,        -32'sd700,      2'b11, 16'd600,        -16'sd600};
        vecs[5] = '{16'd1,     16'd0,   16'd1,     16'd0,   32'h7FFF_FFFF,  32'h8000_0000,  2'b11, 16'd1023,       -16'sd1023};
        vecs[6] = '{16'd256,   16'd0,   16'd256,   16'd0,   32'd1023,       -32'sd1024,     2'b11, 16'd1023,       -16'sd1023};
        vecs[7] = '{16'd256,   16'd0,   16'd256,   16'd256, -32'sd200,      32'd500,        2'b01, -16'sd200,      16'd0};

        reset = 1'b1; encoder_a = '0; encoder_b = '0; enable = '0;
        kp = '0; ki = '0; desired_vel = '0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            encoder_a = ~encoder_a;
            if (k % 2 == 1) encoder_b = ~encoder_b;
        end
        chk("rst_pos0", actual_pos[31:0], 32'd0);
        chk("rst_pos1", actual_pos[63:32], 32'd0);
        chk("rst_vel", actual_vel[31:0] | actual_vel[63:32], 32'd0);
        chk("rst_ctrl", ctrl_signal, 32'd0);
        chk("rst_misc", {22'd0, pwm_out, dir1, dir2, enc_err, sample_tick, busy}, 32'd0);
        encoder_a = '0; encoder_b = '0;
        @(negedge clk);
        reset = 1'b0;
        cyc(4);
        chk("post_rst_pos", actual_pos[31:0], 32'd0);

        for (int i = 0; i < 8; i++) begin
            clear_integ();
            apply(vecs[i]);
            wait_tick();
            if (i == 0) chk("busy_at_tick", {31'd0, busy}, 32'd0);
            cyc(1);
            if (i == 0) chk("busy_after_tick", {31'd0, busy}, 32'd1);
            cyc(8);
            chk($sformatf("vec%0d_latency", i), ctrl_signal, 32'd0);
            cyc(1);
            chk($sformatf("vec%0d_ctrl0", i), {16'd0, ctrl_signal[15:0]}, {16'd0, vecs[i].e0});
            chk($sformatf("vec%0d_ctrl1", i), {16'd0, ctrl_signal[31:16]}, {16'd0, vecs[i].e1});
            if (i == 0) chk("busy_after_commit", {31'd0, busy}, 32'd0);
        end

        clear_integ();
        kp = '0; ki = '0; desired_vel = '0;
        wait_tick();
        for (int k = 0; k < 50; k++) enc_step(1);
        wait_tick();
        chk("fwd_pos", actual_pos[31:0], 32'd50);
        cyc(1);
        chk("fwd_vel", actual_vel[31:0], 32'd50);
        for (int k = 0; k < 50; k++) enc_step(-1);
        wait_tick();
        chk("rev_pos", actual_pos[31:0], 32'd0);
        cyc(1);
        chk("rev_vel", actual_vel[31:0], 32'hFFFF_FFCE);
        chk("ch1_vel", actual_vel[63:32], 32'd0);

        {encoder_a[0], encoder_b[0]} = 2'b11;
        cyc(6);
        chk("err_pos", actual_pos[31:0], 32'd0);
        chk("err_flag", {30'd0, enc_err}, 32'd1);
        {encoder_a[0], encoder_b[0]} = 2'b00;
        cyc(6);
        chk("err_sticky", {30'd0, enc_err}, 32'd1);
        chk("err_pos2", actual_pos[31:0], 32'd0);
        wait_tick();
        cyc(10);

        clear_integ();
        apply('{16'd256, 16'd0, 16'd65535, 16'd0, 32'd100, -32'sd8000, 2'b11, 16'd0, 16'd0});
        wait_tick();
        cyc(1100);
        pwm_count(c0, c1);
        chk("pwm0_duty", c0, 32'd100);
        chk("pwm1_duty", c1, 32'd1023);
        chk("pwm_dirs", {28'd0, dir1, dir2}, 32'b0110);

        clear_integ();
        apply('{16'd65535, 16'd256, 16'd0, 16'd0, -32'sd8000, 32'd0, 2'b11, 16'd0, 16'd0});
        for (int k = 0; k < 20; k++) begin
            wait_tick();
            cyc(10);
        end
        chk("aw_sat", {16'd0, ctrl_signal[15:0]}, 32'h0000_FC01);
        desired_vel[31:0] = 32'd0;
        wait_tick();
        cyc(10);
        chk("aw_release", {16'd0, ctrl_signal[15:0]}, 32'd0);

        clear_integ();
        apply('{16'd256, 16'd0, 16'd0, 16'd256, -32'sd200, 32'd100, 2'b11, 16'd0, 16'd0});
        wait_tick();
        cyc(10);
        chk("en_pre_ctrl1", {16'd0, ctrl_signal[31:16]}, 32'd100);
        enable = 2'b01;
        wait_tick();
        cyc(10);
        chk("en_off_ctrl1", {16'd0, ctrl_signal[31:16]}, 32'd0);
        chk("en_off_ctrl0", {16'd0, ctrl_signal[15:0]}, 32'h0000_FF38);
        cyc(1100);
        pwm_count(c0, c1);
        chk("en_off_pwm1", c1, 32'd0);
        chk("en_off_pwm0", c0, 32'd200);
        chk("en_off_dirs", {28'd0, dir1, dir2}, 32'b0001);
        wait_tick();
        cyc(11);
        enable = 2'b11;
        wait_tick();
        cyc(10);
        chk("en_reenable_ctrl1", {16'd0, ctrl_signal[31:16]}, 32'd100);

        reset = 1'b1;
        cyc(2);
        chk("rst2_enc_err", {30'd0, enc_err}, 32'd0);
        chk("rst2_ctrl", ctrl_signal, 32'd0);
        reset = 1'b0;
        cyc(2);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
